uart_apb_regs_p: RTL and testbench
==================================

# uart_apb_regs_p

Parametrised APB3 register slave for the UART: the next-generation successor of the UART APB config block. Adds PREADY/PSLVERR, a configurable base address and interrupt count, self-clearing command bits, sticky W1C interrupt status with a registered IRQ output, and FIFO push/pop strobes generated directly from TX_DATA writes and RX_DATA reads. Sits between the APB bridge and the UART TX/RX datapath and FIFOs.

## Interface
- BASE_ADDR, 32'h40001000, APB base address; full 32-bit match on BASE_ADDR+offset.
- INT_NUM, 9, interrupt sources, 1..16.
- DATA_W, 10, UART data word width, 5..16.
- CNT_W, 5, FIFO level width.
- CLKDIV_RST, 12'h16, reset value of CLKDIV.
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- psel, penable, pwrite  in  1  APB3 control.
- paddr, pwdata  in  32  APB address and write data.
- prdata  out  32  read data, registered.
- pready  out  1  constant 1; no wait states.
- pslverr  out  1  error response; see Configuration.
- tx_push  out  1  one-cycle TX FIFO push; tx_data  out  DATA_W  push data.
- tx_full, rx_empty  in  1  FIFO flags.
- rx_pop  out  1  one-cycle RX FIFO pop; rx_data  in  DATA_W  show-ahead FIFO head.
- tx_num, rx_num  in  CNT_W  FIFO levels.
- int_evt  in  INT_NUM  single-cycle interrupt events.
- irq  out  1  registered OR of enabled pending interrupts.
- top_ctrl  out  32  TOP_CTRL fields: watermarks, rx_enable, pulses.
- pe_ctrl  out  32  PE_CTRL fields: clkdiv, oversampling, framing.

## Operation
- Register map (offset): 0x00 TX_DATA W; 0x04 TOP_CTRL RW; 0x08 PE_CTRL RW; 0x0C INT_EN RW; 0x10 INT_STA R/W1C; 0x14 FIFO_STA R; 0x18 INT_MSK R (=STA&EN); 0x1C RX_DATA R.
- TOP_CTRL: [28:24] tx_wm (rst 8), [20:16] rx_wm (rst 8), [1] rx_enable (rst 0). Bits [11:8] tx_fifo_clr, rx_fifo_clr, tx_logic_clr, rx_logic_clr and [0] update are self-clearing: high exactly one cycle after the write, then 0; they always read as 0.
- PE_CTRL: [31:20] clkdiv (CLKDIV_RST), [19:16] oversampling (4'hf), [15:12] interval_bit (0), [11] error_ignore, [7] rts, [6] cts, [5] stop_bit, [4] parity_en, [3:2] parity, [1:0] data_bit (rst 1). Unused bits read 0.
- FIFO_STA: [12:8] tx_num, [4:0] rx_num, zero-extended; width follows CNT_W.
- TX_DATA write with !tx_full: tx_data <= pwdata[DATA_W-1:0], tx_push high next cycle. With tx_full: write dropped, no push. Reads return 0.
- RX_DATA read with !rx_empty: prdata = rx_data, rx_pop high one cycle. With rx_empty: prdata 0, no pop.
- INT_STA[i] set on int_evt[i]; cleared by writing 1 to bit i. Set and clear in the same cycle: set wins. Bits >= INT_NUM read 0.
- irq <= |(INT_STA & INT_EN), registered one cycle.
- Reset: every output and register goes to the reset value above; prdata, tx_push, rx_pop, pulses, irq, pslverr all 0.

## Timing
- Setup cycle (psel & !penable): address decoded; prdata registered, valid during access phase.
- Access cycle (psel & penable): writes commit at its rising edge; pulses, tx_push and rx_pop are asserted the following cycle for exactly one cycle.
- rx_pop is evaluated on the access cycle's rx_empty. Back-to-back RX_DATA reads pop once each.
- int_evt to INT_STA: 1 cycle. INT_STA to irq: 1 further cycle.
- Reset asserted mid-transfer: the pending pulse or push is discarded.

## Configuration
- UART_APB_PSLVERR_EN defined: pslverr is high in the access cycle for unmapped offsets, TX_DATA write when tx_full, RX_DATA read when rx_empty, and writes to read-only registers. The access has no side effect.
- Not defined: pslverr is tied 0. The same accesses are silently ignored.

## Structure
- Package uart_apb_pkg: register offsets, field bit positions and reset values, TOP_CTRL/PE_CTRL field typedefs.
- Sub-module uart_apb_int_ctrl: sticky INT_STA, W1C and the irq register, parametrised by INT_NUM.

## Test plan
- Reset, then read all eight offsets -> PE_CTRL=32'h016F_0001, TOP_CTRL=32'h0808_0000, all others 0, irq=0.
- Write TOP_CTRL=32'h0000_0F03 -> rx_enable=1 persists; clr bits and update high exactly one cycle; readback 32'h0000_0002.
- Write TX_DATA 10'h155 with tx_full=0, then again with tx_full=1 -> single tx_push carrying 10'h155; second write gives pslverr=1 when UART_APB_PSLVERR_EN is defined.
- rx_data=10'h2A3 with rx_empty=0, read 0x1C -> prdata=32'h2A3 and one rx_pop. Repeat with rx_empty=1 -> prdata=0, no pop.
- INT_EN=9'h004; pulse int_evt[2] and int_evt[5] -> INT_STA=9'h024, INT_MSK=9'h004, irq=1 two cycles after the event. W1C 9'h004 in the same cycle as int_evt[2] -> bit stays set.
- Access offset 0x20 -> prdata=0; pslverr=1 only with the macro defined.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB register slave: word indices, field
// layouts, masks and reset values.
package uart_apb_pkg;

  localparam logic [2:0] IDX_TX_DATA  = 3'd0;
  localparam logic [2:0] IDX_TOP_CTRL = 3'd1;
  localparam logic [2:0] IDX_PE_CTRL  = 3'd2;
  localparam logic [2:0] IDX_INT_EN   = 3'd3;
  localparam logic [2:0] IDX_INT_STA  = 3'd4;
  localparam logic [2:0] IDX_FIFO_STA = 3'd5;
  localparam logic [2:0] IDX_INT_MSK  = 3'd6;
  localparam logic [2:0] IDX_RX_DATA  = 3'd7;

  localparam logic [31:0] PE_CTRL_MASK = 32'hFFFF_F8FF;
  localparam logic [4:0]  WM_RST       = 5'd8;

  typedef struct packed {
    logic [2:0] rsvd29;
    logic [4:0] tx_wm;
    logic [2:0] rsvd21;
    logic [4:0] rx_wm;
    logic [3:0] rsvd12;
    logic       tx_fifo_clr;
    logic       rx_fifo_clr;
    logic       tx_logic_clr;
    logic       rx_logic_clr;
    logic [5:0] rsvd2;
    logic       rx_enable;
    logic       update;
  } top_ctrl_t;

  typedef struct packed {
    logic [11:0] clkdiv;
    logic [3:0]  oversampling;
    logic [3:0]  interval_bit;
    logic        error_ignore;
    logic [2:0]  rsvd8;
    logic        rts;
    logic        cts;
    logic        stop_bit;
    logic        parity_en;
    logic [1:0]  parity;
    logic [1:0]  data_bit;
  } pe_ctrl_t;

  // Offset relative to the base must be word aligned and inside the 32-byte window.
  function automatic logic addr_mapped(input logic [31:0] rel);
    return (rel[31:5] == 27'd0) && (rel[1:0] == 2'd0);
  endfunction

endpackage

// File: rtl/uart_apb_int_ctrl.sv
// Sticky interrupt status with write-1-to-clear and a registered irq output.
module uart_apb_int_ctrl #(
  parameter int INT_NUM = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INT_NUM-1:0] int_evt,
  input  logic [INT_NUM-1:0] int_en,
  input  logic               clr_we,
  input  logic [INT_NUM-1:0] clr_mask,
  output logic [INT_NUM-1:0] int_sta,
  output logic               irq
);

  logic [INT_NUM-1:0] clr;

  assign clr = clr_we ? clr_mask : '0;

  // A new event in the same cycle as its clear keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_sta <= '0;
      irq     <= 1'b0;
    end else begin
      int_sta <= (int_sta & ~clr) | int_evt;
      irq     <= |(int_sta & int_en);
    end
  end

endmodule

// File: rtl/uart_apb_regs_p.sv
// APB3 register slave for the UART. Define UART_APB_PSLVERR_EN to report
// illegal accesses on pslverr; otherwise they are silently ignored.
module uart_apb_regs_p
  import uart_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_1000,
  parameter int          INT_NUM    = 9,
  parameter int          DATA_W     = 10,
  parameter int          CNT_W      = 5,
  parameter logic [11:0] CLKDIV_RST = 12'h16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  output logic               tx_push,
  output logic [DATA_W-1:0]  tx_data,
  input  logic               tx_full,
  input  logic               rx_empty,
  output logic               rx_pop,
  input  logic [DATA_W-1:0]  rx_data,
  input  logic [CNT_W-1:0]   tx_num,
  input  logic [CNT_W-1:0]   rx_num,
  input  logic [INT_NUM-1:0] int_evt,
  output logic               irq,
  output logic [31:0]        top_ctrl,
  output logic [31:0]        pe_ctrl
);

  localparam logic [31:0] PE_RST = {CLKDIV_RST, 20'hF_0001};

  // APB3: setup (psel & !penable) decodes and registers prdata/pslverr;
  // access (psel & penable) completes in one cycle (pready=1) and commits at its edge.
  logic [31:0]        rel;
  logic [2:0]         idx;
  logic               mapped, setup, wr_acc, rd_acc;
  logic [4:0]         tx_wm_q, rx_wm_q;
  logic               rx_en_q;
  logic [4:0]         pulse_q;
  logic [31:0]        pe_q;
  logic [INT_NUM-1:0] int_en_q, int_sta;
  logic [31:0]        rd_val;
  top_ctrl_t          top_w, top_s, top_o;

  assign rel    = paddr - BASE_ADDR;
  assign idx    = rel[4:2];
  assign mapped = addr_mapped(rel);
  assign setup  = psel & ~penable;
  assign wr_acc = psel & penable & pwrite & mapped;
  assign rd_acc = psel & penable & ~pwrite & mapped;
  assign top_w  = pwdata;
  assign pready = 1'b1;

  always_comb begin
    top_s           = '0;
    top_s.tx_wm     = tx_wm_q;
    top_s.rx_wm     = rx_wm_q;
    top_s.rx_enable = rx_en_q;
    top_o              = top_s;
    top_o.tx_fifo_clr  = pulse_q[4];
    top_o.rx_fifo_clr  = pulse_q[3];
    top_o.tx_logic_clr = pulse_q[2];
    top_o.rx_logic_clr = pulse_q[1];
    top_o.update       = pulse_q[0];
  end

  assign top_ctrl = top_o;
  assign pe_ctrl  = pe_q;

  always_comb begin
    rd_val = '0;
    case (idx)
      IDX_TOP_CTRL: rd_val = top_s;
      IDX_PE_CTRL:  rd_val = pe_q;
      IDX_INT_EN:   rd_val[INT_NUM-1:0] = int_en_q;
      IDX_INT_STA:  rd_val[INT_NUM-1:0] = int_sta;
      IDX_FIFO_STA: begin
        rd_val[8 +: CNT_W]  = tx_num;
        rd_val[CNT_W-1:0]   = rx_num;
      end
      IDX_INT_MSK:  rd_val[INT_NUM-1:0] = int_sta & int_en_q;
      IDX_RX_DATA:  if (!rx_empty) rd_val[DATA_W-1:0] = rx_data;
      default:      rd_val = '0;
    endcase
    if (!mapped || pwrite) rd_val = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prdata   <= '0;
      tx_push  <= 1'b0;
      tx_data  <= '0;
      rx_pop   <= 1'b0;
      tx_wm_q  <= WM_RST;
      rx_wm_q  <= WM_RST;
      rx_en_q  <= 1'b0;
      pulse_q  <= '0;
      pe_q     <= PE_RST;
      int_en_q <= '0;
    end else begin
      tx_push <= 1'b0;
      rx_pop  <= 1'b0;
      pulse_q <= '0;
      if (setup) prdata <= rd_val;
      if (wr_acc) begin
        case (idx)
          IDX_TX_DATA: if (!tx_full) begin
            tx_data <= pwdata[DATA_W-1:0];
            tx_push <= 1'b1;
          end
          IDX_TOP_CTRL: begin
            tx_wm_q <= top_w.tx_wm;
            rx_wm_q <= top_w.rx_wm;
            rx_en_q <= top_w.rx_enable;
            pulse_q <= {top_w.tx_fifo_clr, top_w.rx_fifo_clr,
                        top_w.tx_logic_clr, top_w.rx_logic_clr, top_w.update};
          end
          IDX_PE_CTRL: pe_q     <= pwdata & PE_CTRL_MASK;
          IDX_INT_EN:  int_en_q <= pwdata[INT_NUM-1:0];
          default: ;
        endcase
      end
      if (rd_acc && idx == IDX_RX_DATA && !rx_empty) rx_pop <= 1'b1;
    end
  end

`ifdef UART_APB_PSLVERR_EN
  logic err, pslverr_q;

  always_comb begin
    err = !mapped;
    if (pwrite && (idx == IDX_FIFO_STA || idx == IDX_INT_MSK || idx == IDX_RX_DATA)) err = 1'b1;
    if (pwrite && idx == IDX_TX_DATA && tx_full) err = 1'b1;
    if (!pwrite && idx == IDX_RX_DATA && rx_empty) err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pslverr_q <= 1'b0;
    else        pslverr_q <= setup & err;
  end

  assign pslverr = pslverr_q;
`else
  assign pslverr = 1'b0;
`endif

  uart_apb_int_ctrl #(.INT_NUM(INT_NUM)) u_int_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .int_evt  (int_evt),
    .int_en   (int_en_q),
    .clr_we   (wr_acc && idx == IDX_INT_STA),
    .clr_mask (pwdata[INT_NUM-1:0]),
    .int_sta  (int_sta),
    .irq      (irq)
  );

endmodule

// File: tb/tb_uart_apb_regs_p.sv
// Directed self-checking bench for uart_apb_regs_p (default parameters).
module tb_uart_apb_regs_p;

  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam int INT_NUM = 9;
  localparam int DATA_W  = 10;
  localparam int CNT_W   = 5;
`ifdef UART_APB_PSLVERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic psel = 0, penable = 0, pwrite = 0;
  logic [31:0] paddr = '0, pwdata = '0, prdata, top_ctrl, pe_ctrl;
  logic pready, pslverr, tx_push, rx_pop, irq;
  logic [DATA_W-1:0] tx_data, rx_data = '0;
  logic tx_full = 0, rx_empty = 1;
  logic [CNT_W-1:0] tx_num = '0, rx_num = '0;
  logic [INT_NUM-1:0] int_evt = '0;

  int checks = 0, passes = 0;
  int push_cnt = 0, pop_cnt = 0, upd_cnt = 0;

  uart_apb_regs_p dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full), .rx_empty(rx_empty),
    .rx_pop(rx_pop), .rx_data(rx_data), .tx_num(tx_num), .rx_num(rx_num),
    .int_evt(int_evt), .irq(irq), .top_ctrl(top_ctrl), .pe_ctrl(pe_ctrl)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_push) push_cnt++;
      if (rx_pop) pop_cnt++;
      if (top_ctrl[0]) upd_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // One APB transfer; returns after the access edge (+1), where strobes are visible.
  task automatic apb_xfer(input logic wr, input logic [7:0] off, input logic [31:0] wdata,
                          input logic [INT_NUM-1:0] evt_acc,
                          output logic [31:0] rdata, output logic err);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = BASE + 32'(off); pwdata = wdata;
    @(posedge clk); #1;
    penable = 1; int_evt = evt_acc;
    rdata = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0; int_evt = '0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [8];
    logic [31:0] rd;
    logic er;
    exp_rd = '{32'h0, 32'h0808_0000, 32'h016F_0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    checks++;
    if (top_ctrl !== 32'h0808_0000 || pe_ctrl !== 32'h016F_0001 || irq !== 1'b0 ||
        tx_push !== 1'b0 || rx_pop !== 1'b0 || pready !== 1'b1 || prdata !== 32'h0)
      $display("FAIL reset_outputs: top=%h pe=%h irq=%b push=%b pop=%b pready=%b prdata=%h",
               top_ctrl, pe_ctrl, irq, tx_push, rx_pop, pready, prdata);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      apb_xfer(1'b0, 8'(i * 4), 32'h0, '0, rd, er);
      checks++;
      if (rd !== exp_rd[i]) $display("FAIL reset_read off=%0h: got %h want %h", i * 4, rd, exp_rd[i]);
      else passes++;
    end
  endtask

  task automatic test_top_ctrl();
    logic [31:0] rd;
    logic er;
    apb_xfer(1'b1, 8'h04, 32'h0000_0F03, '0, rd, er);
    checks++;
    if (top_ctrl !== 32'h0000_0F03 || er !== 1'b0)
      $display("FAIL top_pulse_on: got %h err=%b want 00000f03 err=0", top_ctrl, er);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (top_ctrl !== 32'h0000_0002) $display("FAIL top_pulse_off: got %h want 00000002", top_ctrl);
    else passes++;
    apb_xfer(1'b0, 8'h04, 32'h0, '0, rd, er);
    checks++;
    if (rd !== 32'h0000_0002 || upd_cnt !== 1)
      $display("FAIL top_readback: got %h upd_cnt=%0d want 00000002 upd_cnt=1", rd, upd_cnt);
    else passes++;
  endtask

  task automatic test_pe_ctrl();
    logic [31:0] rd;
    logic er;
    apb_xfer(1'b1, 8'h08, 32'hFFFF_FFFF, '0, rd, er);
    apb_xfer(1'b0, 8'h08, 32'h0, '0, rd, er);
    checks++;
    if (rd !== 32'hFFFF_F8FF || pe_ctrl !== 32'hFFFF_F8FF)
      $display("FAIL pe_ctrl_mask: read %h out %h want fffff8ff", rd, pe_ctrl);
    else passes++;
  endtask

  task automatic test_tx_data();
    logic [31:0] rd;
    logic er;
    tx_full = 0;
    apb_xfer(1'b1, 8'h00, 32'hABCD_E155, '0, rd, er);
    checks++;
    if (tx_push !== 1'b1 || tx_data !== 10'h155 || er !== 1'b0)
      $display("FAIL tx_push: push=%b data=%h err=%b want 1 155 0", tx_push, tx_data, er);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (tx_push !== 1'b0) $display("FAIL tx_push_width: push=%b want 0", tx_push);
    else passes++;
    tx_full = 1;
    apb_xfer(1'b1, 8'h00, 32'h0000_03FF, '0, rd, er);
    checks++;
    if (tx_push !== 1'b0 || tx_data !== 10'h155 || er !== EXP_ERR || push_cnt !== 1)
      $display("FAIL tx_full_drop: push=%b data=%h err=%b cnt=%0d want 0 155 %b 1",
               tx_push, tx_data, er, push_cnt, EXP_ERR);
    else passes++;
    tx_full = 0;
  endtask

  task automatic test_rx_data();
    logic [31:0] rd;
    logic er;
    rx_data = 10'h2A3; rx_empty = 0;
    apb_xfer(1'b0, 8'h1C, 32'h0, '0, rd, er);
    checks++;
    if (rd !== 32'h0000_02A3 || rx_pop !== 1'b1 || er !== 1'b0)
      $display("FAIL rx_read: data=%h pop=%b err=%b want 000002a3 1 0", rd, rx_pop, er);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (rx_pop !== 1'b0) $display("FAIL rx_pop_width: pop=%b want 0", rx_pop);
    else passes++;
    rx_empty = 1;
    apb_xfer(1'b0, 8'h1C, 32'h0, '0, rd, er);
    checks++;
    if (rd !== 32'h0 || rx_pop !== 1'b0 || er !== EXP_ERR || pop_cnt !== 1)
      $display("FAIL rx_empty: data=%h pop=%b err=%b cnt=%0d want 0 0 %b 1", rd, rx_pop, er, pop_cnt, EXP_ERR);
    else passes++;
  endtask

  task automatic test_fifo_sta();
    logic [31:0] rd;
    logic er;
    tx_num = 5'h13; rx_num = 5'h07;
    apb_xfer(1'b1, 8'h14, 32'hFFFF_FFFF, '0, rd, er);
    checks++;
    if (er !== EXP_ERR) $display("FAIL ro_write_err: err=%b want %b", er, EXP_ERR);
    else passes++;
    apb_xfer(1'b0, 8'h14, 32'h0, '0, rd, er);
    checks++;
    if (rd !== 32'h0000_1307) $display("FAIL fifo_sta: got %h want 00001307", rd);
    else passes++;
  endtask

  task automatic test_interrupts();
    logic [31:0] rd;
    logic er;
    apb_xfer(1'b1, 8'h0C, 32'h0000_0004, '0, rd, er);
    @(posedge clk); #1;
    int_evt = 9'h024;
    @(posedge clk); #1;
    int_evt = '0;
    checks++;
    if (irq !== 1'b0) $display("FAIL irq_latency1: irq=%b want 0", irq);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) $display("FAIL irq_latency2: irq=%b want 1", irq);
    else passes++;
    apb_xfer(1'b0, 8'h10, 32'h0, '0, rd, er);
    checks++;
    if (rd !== 32'h0000_0024) $display("FAIL int_sta: got %h want 00000024", rd);
    else passes++;
    apb_xfer(1'b0, 8'h18, 32'h0, '0, rd, er);
    checks++;
    if (rd !== 32'h0000_0004) $display("FAIL int_msk: got %h want 00000004", rd);
    else passes++;
    apb_xfer(1'b1, 8'h10, 32'h0000_0004, 9'h004, rd, er);
    apb_xfer(1'b0, 8'h10, 32'h0, '0, rd, er);
    checks++;
    if (rd !== 32'h0000_0024) $display("FAIL w1c_set_wins: got %h want 00000024", rd);
    else passes++;
    apb_xfer(1'b1, 8'h10, 32'hFFFF_FE24, '0, rd, er);
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b0 || er !== 1'b0) $display("FAIL irq_clear: irq=%b err=%b want 0 0", irq, er);
    else passes++;
    apb_xfer(1'b0, 8'h10, 32'h0, '0, rd, er);
    checks++;
    if (rd !== 32'h0) $display("FAIL w1c_clear: got %h want 00000000", rd);
    else passes++;
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    logic er;
    apb_xfer(1'b0, 8'h20, 32'h0, '0, rd, er);
    checks++;
    if (rd !== 32'h0 || er !== EXP_ERR) $display("FAIL unmapped: data=%h err=%b want 0 %b", rd, er, EXP_ERR);
    else passes++;
    apb_xfer(1'b1, 8'h20, 32'hFFFF_FFFF, '0, rd, er);
    apb_xfer(1'b0, 8'h04, 32'h0, '0, rd, er);
    checks++;
    if (rd !== 32'h0000_0002) $display("FAIL unmapped_no_effect: top=%h want 00000002", rd);
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic er;
    apb_xfer(1'b1, 8'h04, 32'h0000_0003, '0, rd, er);
    checks++;
    if (top_ctrl !== 32'h0000_0003) $display("FAIL pre_reset_pulse: got %h want 00000003", top_ctrl);
    else passes++;
    rst_n = 0; #1;
    checks++;
    if (top_ctrl !== 32'h0808_0000 || tx_push !== 1'b0)
      $display("FAIL reset_discard: top=%h push=%b want 08080000 0", top_ctrl, tx_push);
    else passes++;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    test_reset();
    test_top_ctrl();
    test_pe_ctrl();
    test_tx_data();
    test_rx_data();
    test_fifo_sta();
    test_interrupts();
    test_unmapped();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
